id_decode_stage: RTL

ID_DECODE_STAGE -- requirements
Module: id_decode_stage

---
 rtl/id_decode_stage_pkg.sv | 66 ++++++
 rtl/id_decode_stage_ctrl_decode.sv | 128 ++++++++++++
 rtl/id_decode_stage.sv | 87 ++++++++
 3 files changed

// File: rtl/id_decode_stage_pkg.sv
// Shared encodings for the decode stage and the ALU.
// Holds the MIPS opcode and funct encodings, the ALU control codes and
// the decoded control bundle passed from id_ctrl_decode to id_decode_stage.
package id_decode_stage_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU control codes
    typedef enum logic [7:0] {
        ALU_NOP  = 8'b00000000,
        ALU_ADD  = 8'b00100000,
        ALU_SUB  = 8'b00100010,
        ALU_AND  = 8'b00100100,
        ALU_OR   = 8'b00100101,
        ALU_XOR  = 8'b00100110,
        ALU_NOR  = 8'b00100111,
        ALU_SLT  = 8'b00101010,
        ALU_J    = 8'b01001111,
        ALU_BEQ  = 8'b01010001,
        ALU_ADDI = 8'b01010101,
        ALU_ANDI = 8'b01011001,
        ALU_ORI  = 8'b01011010,
        ALU_XORI = 8'b01011011,
        ALU_LUI  = 8'b01011100,
        ALU_LW   = 8'b11100011,
        ALU_SW   = 8'b11101011
    } aluctrl_e;

    typedef struct packed {
        aluctrl_e    alucontrol;
        logic        regwrite;
        logic        memtoreg;
        logic        memwrite;
        logic        alusrc;
        logic        regdst;
        logic        branch;
        logic        jump;
        logic [31:0] imm_ext;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  wreg;
        logic [31:0] jaddr;
        logic        illegal;
    } ctrl_bundle_t;

endpackage

// File: rtl/id_decode_stage_ctrl_decode.sv
// Combinational MIPS instruction decoder.
// Optional feature macro: DECODE_ILLEGAL_EN (flag unlisted instructions).
// Ports:
//   instr  - instruction word
//   pc     - address of instr (used for the jump target)
//   bundle - decoded control bundle
// Unlisted instructions produce an all-zero control bundle (register
// fields and jump target still reflect the raw instruction).
module id_ctrl_decode
    import id_decode_stage_pkg::*;
(
    input  logic [31:0]  instr,
    input  logic [31:0]  pc,
    output ctrl_bundle_t bundle
);

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] pc_plus4;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic        known;
    logic        unused_pc_bits;

    assign op             = instr[31:26];
    assign funct          = instr[5:0];
    assign pc_plus4       = pc + 32'd4;
    assign imm_sext       = {{16{instr[15]}}, instr[15:0]};
    assign imm_zext       = {16'h0000, instr[15:0]};
    assign unused_pc_bits = ^pc_plus4[27:0];

    always_comb begin
        bundle       = '0;
        bundle.rs    = instr[25:21];
        bundle.rt    = instr[20:16];
        bundle.rd    = instr[15:11];
        bundle.jaddr = {pc_plus4[31:28], instr[25:0], 2'b00};
        known        = 1'b1;

        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  bundle.alucontrol = ALU_ADD;
                    FN_SUB:  bundle.alucontrol = ALU_SUB;
                    FN_AND:  bundle.alucontrol = ALU_AND;
                    FN_OR:   bundle.alucontrol = ALU_OR;
                    FN_XOR:  bundle.alucontrol = ALU_XOR;
                    FN_NOR:  bundle.alucontrol = ALU_NOR;
                    FN_SLT:  bundle.alucontrol = ALU_SLT;
                    // The all-zero word is the canonical nop and stays legal.
                    default: known = (instr == '0);
                endcase
                if (known && instr != '0) begin
                    bundle.regwrite = 1'b1;
                    bundle.regdst   = 1'b1;
                    bundle.wreg     = instr[15:11];
                end
            end
            OP_ADDI: begin
                bundle.alucontrol = ALU_ADDI;
                bundle.regwrite   = 1'b1;
                bundle.alusrc     = 1'b1;
                bundle.imm_ext    = imm_sext;
                bundle.wreg       = instr[20:16];
            end
            OP_ANDI: begin
                bundle.alucontrol = ALU_ANDI;
                bundle.regwrite   = 1'b1;
                bundle.alusrc     = 1'b1;
                bundle.imm_ext    = imm_zext;
                bundle.wreg       = instr[20:16];
            end
            OP_ORI: begin
                bundle.alucontrol = ALU_ORI;
                bundle.regwrite   = 1'b1;
                bundle.alusrc     = 1'b1;
                bundle.imm_ext    = imm_zext;
                bundle.wreg       = instr[20:16];
            end
            OP_XORI: begin
                bundle.alucontrol = ALU_XORI;
                bundle.regwrite   = 1'b1;
                bundle.alusrc     = 1'b1;
                bundle.imm_ext    = imm_zext;
                bundle.wreg       = instr[20:16];
            end
            OP_LUI: begin
                // Zero-extended; the ALU swaps halves to form imm<<16.
                bundle.alucontrol = ALU_LUI;
                bundle.regwrite   = 1'b1;
                bundle.alusrc     = 1'b1;
                bundle.imm_ext    = imm_zext;
                bundle.wreg       = instr[20:16];
            end
            OP_LW: begin
                bundle.alucontrol = ALU_LW;
                bundle.regwrite   = 1'b1;
                bundle.memtoreg   = 1'b1;
                bundle.alusrc     = 1'b1;
                bundle.imm_ext    = imm_sext;
                bundle.wreg       = instr[20:16];
            end
            OP_SW: begin
                bundle.alucontrol = ALU_SW;
                bundle.memwrite   = 1'b1;
                bundle.alusrc     = 1'b1;
                bundle.imm_ext    = imm_sext;
            end
            OP_BEQ: begin
                bundle.alucontrol = ALU_BEQ;
                bundle.branch     = 1'b1;
                bundle.imm_ext    = imm_sext;
            end
            OP_J: begin
                bundle.alucontrol = ALU_J;
                bundle.jump       = 1'b1;
            end
            default: known = 1'b0;
        endcase

`ifdef DECODE_ILLEGAL_EN
        bundle.illegal = !known;
`else
        bundle.illegal = 1'b0;
`endif
    end

endmodule

// File: rtl/id_decode_stage.sv
// Instruction decode pipeline stage: single-entry valid/ready register
// holding the decoded control bundle between fetch and execute.
// Optional feature macro: DECODE_ILLEGAL_EN (flag unlisted instructions).
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   in_valid/in_ready    - handshake from fetch; in_instr, in_pc payload
//   flush                - discard held bundle, refuse input this cycle
//   out_valid/out_ready  - handshake toward execute
//   alucontrol .. jump   - datapath controls
//   imm_ext, rs, rt, rd, wreg, jaddr, illegal - decoded fields
module id_decode_stage
    import id_decode_stage_pkg::*;
#(
    parameter int ALUCTRL_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [31:0]          in_pc,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic                 regwrite,
    output logic                 memtoreg,
    output logic                 memwrite,
    output logic                 alusrc,
    output logic                 regdst,
    output logic                 branch,
    output logic                 jump,
    output logic [31:0]          imm_ext,
    output logic [4:0]           rs,
    output logic [4:0]           rt,
    output logic [4:0]           rd,
    output logic [4:0]           wreg,
    output logic [31:0]          jaddr,
    output logic                 illegal
);

    ctrl_bundle_t dec;
    ctrl_bundle_t bundle_q;
    logic         valid_q;
    logic         accept;

    id_ctrl_decode u_decode (
        .instr  (in_instr),
        .pc     (in_pc),
        .bundle (dec)
    );

    assign in_ready = !rst && !flush && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else if (flush) begin
            valid_q  <= 1'b0;
        end else if (accept) begin
            valid_q  <= 1'b1;
            bundle_q <= dec;
        end else if (out_ready) begin
            valid_q  <= 1'b0;
        end
    end

    assign out_valid  = valid_q;
    assign alucontrol = bundle_q.alucontrol;
    assign regwrite   = bundle_q.regwrite;
    assign memtoreg   = bundle_q.memtoreg;
    assign memwrite   = bundle_q.memwrite;
    assign alusrc     = bundle_q.alusrc;
    assign regdst     = bundle_q.regdst;
    assign branch     = bundle_q.branch;
    assign jump       = bundle_q.jump;
    assign imm_ext    = bundle_q.imm_ext;
    assign rs         = bundle_q.rs;
    assign rt         = bundle_q.rt;
    assign rd         = bundle_q.rd;
    assign wreg       = bundle_q.wreg;
    assign jaddr      = bundle_q.jaddr;
    assign illegal    = bundle_q.illegal;

endmodule
